// File: rtl/countdown_session_ctrl.sv
// countdown_session_ctrl: drives a countdown timer for one answer session and presents
// status plus a blinking two-digit BCD display of the remaining seconds.
module countdown_session_ctrl #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int DEFAULT_SEC = 10,
   parameter int WARN_SEC    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_arm,
   input  logic [3:0] i_sec_cfg,
   input  logic       i_pause,
   input  logic       i_done,
   input  logic       i_abort,
   output logic       o_tmr_start,
   output logic       o_tmr_en,
   output logic [3:0] o_tmr_init,
   input  logic       i_tmr_timeout,
   input  logic [3:0] i_tmr_sec,
   output logic       o_busy,
   output logic       o_paused,
   output logic       o_finished,
   output logic       o_expired,
   output logic [3:0] o_result_sec,
   output logic       o_disp_en,
   output logic [7:0] o_disp_bcd
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_PAUSE  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   localparam logic [2:0] S_EXPIRE = 3'd5;
   localparam logic [31:0] HALF_LAST = 32'(CLK_FREQ / 4 - 1);
   localparam logic [3:0]  DEF       = 4'(DEFAULT_SEC);
   localparam logic [3:0]  WARN      = 4'(WARN_SEC);

   logic [2:0]  r_state;
   logic [31:0] r_blink_cnt;
   logic        r_phase;
   logic        r_in_warn;
   logic [2:0]  w_next;
   logic        w_capture;
   logic [3:0]  w_result;
   logic [3:0]  w_disp_sec;
   logic        w_tens;
   logic [3:0]  w_units;
   logic        w_active;
   logic        w_warn;
   logic        w_wrap;
   logic        w_restart;
   logic        w_phase;
   logic [31:0] w_cnt;

   // Event priority: abort > arm > timeout > done > pause.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      if (i_abort)
         w_next = S_IDLE;
      else if (i_arm)
         w_next = S_LOAD;
      else
         case (r_state)
            S_LOAD: w_next = S_RUN;
            S_RUN, S_PAUSE: begin
               if (i_tmr_timeout)
                  w_next = S_EXPIRE;
               else if (i_done) begin
                  w_next    = S_FINISH;
                  w_capture = 1'b1;
               end else if (i_pause)
                  w_next = (r_state == S_RUN) ? S_PAUSE : S_RUN;
            end
            default: w_next = r_state;
         endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_comb begin
      w_result   = w_capture ? i_tmr_sec : o_result_sec;
      w_active   = (w_next == S_LOAD) || (w_next == S_RUN) || (w_next == S_PAUSE);
      w_disp_sec = w_active ? i_tmr_sec : (w_next == S_FINISH) ? w_result : 4'd0;
      w_tens     = w_disp_sec >= 4'd10;
      w_units    = w_disp_sec - (w_tens ? 4'd10 : 4'd0);
      w_warn     = (w_next == S_RUN) && (i_tmr_sec != 4'd0) && (i_tmr_sec <= WARN);
      w_wrap     = r_blink_cnt == HALF_LAST;
      w_restart  = !w_warn || !r_in_warn;
      w_phase    = w_restart ? 1'b1 : w_wrap ? ~r_phase : r_phase;
      w_cnt      = (w_restart || w_wrap) ? 32'd0 : r_blink_cnt + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_blink_cnt  <= 32'd0;
         r_phase      <= 1'b1;
         r_in_warn    <= 1'b0;
         o_tmr_start  <= 1'b0;
         o_tmr_en     <= 1'b0;
         o_tmr_init   <= DEF;
         o_busy       <= 1'b0;
         o_paused     <= 1'b0;
         o_finished   <= 1'b0;
         o_expired    <= 1'b0;
         o_result_sec <= 4'd0;
         o_disp_en    <= 1'b0;
         o_disp_bcd   <= 8'h00;
      end else begin
         r_state      <= w_next;
         r_blink_cnt  <= w_cnt;
         r_phase      <= w_phase;
         r_in_warn    <= w_warn;
         o_tmr_start  <= w_next == S_LOAD;
         o_tmr_en     <= w_next == S_RUN;
         o_tmr_init   <= (!i_abort && i_arm) ? ((i_sec_cfg == 4'd0) ? DEF : i_sec_cfg) : o_tmr_init;
         o_busy       <= w_active;
         o_paused     <= w_next == S_PAUSE;
         o_finished   <= w_next == S_FINISH;
         o_expired    <= w_next == S_EXPIRE;
         o_result_sec <= w_result;
         o_disp_en    <= (w_next == S_IDLE) ? 1'b0 : w_warn ? w_phase : 1'b1;
         o_disp_bcd   <= {3'b000, w_tens, w_units};
      end
   end
endmodule

// File: tb/tb_countdown_session_ctrl.sv
// tb_countdown_session_ctrl: directed checks of the session controller with the timer
// side (i_tmr_sec / i_tmr_timeout) driven directly by the bench.
module tb_countdown_session_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_arm = 1'b0, i_pause = 1'b0, i_done = 1'b0, i_abort = 1'b0;
   logic [3:0] i_sec_cfg = 4'd0;
   logic       i_tmr_timeout = 1'b0;
   logic [3:0] i_tmr_sec = 4'd0;
   logic       o_tmr_start, o_tmr_en, o_busy, o_paused, o_finished, o_expired, o_disp_en;
   logic [3:0] o_tmr_init, o_result_sec;
   logic [7:0] o_disp_bcd;
   int checks = 0;
   int failures = 0;

   countdown_session_ctrl #(.CLK_FREQ(8), .DEFAULT_SEC(10), .WARN_SEC(3)) dut (
      .clk(clk), .rst_n(rst_n), .i_arm(i_arm), .i_sec_cfg(i_sec_cfg), .i_pause(i_pause),
      .i_done(i_done), .i_abort(i_abort), .o_tmr_start(o_tmr_start), .o_tmr_en(o_tmr_en),
      .o_tmr_init(o_tmr_init), .i_tmr_timeout(i_tmr_timeout), .i_tmr_sec(i_tmr_sec),
      .o_busy(o_busy), .o_paused(o_paused), .o_finished(o_finished), .o_expired(o_expired),
      .o_result_sec(o_result_sec), .o_disp_en(o_disp_en), .o_disp_bcd(o_disp_bcd)
   );

   always #5 clk = ~clk;

   // {busy, paused, finished, expired, tmr_en}
   wire [4:0] flags = {o_busy, o_paused, o_finished, o_expired, o_tmr_en};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (2) tick;
      checks++;
      if (flags !== 5'b00000 || o_tmr_start !== 1'b0 || o_disp_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b start=%b den=%b exp=00000/0/0", flags, o_tmr_start, o_disp_en);
      end
      checks++;
      if (o_tmr_init !== 4'd10 || o_result_sec !== 4'd0 || o_disp_bcd !== 8'h00) begin
         failures++;
         $display("FAIL reset_values init=%0d res=%0d bcd=%h exp=10/0/00", o_tmr_init, o_result_sec, o_disp_bcd);
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_expiry;
      i_tmr_sec = 4'd3; i_sec_cfg = 4'd3; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      checks++;
      if (o_tmr_start !== 1'b1 || o_tmr_init !== 4'd3 || o_tmr_en !== 1'b0 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL exp_load start=%b init=%0d en=%b busy=%b exp=1/3/0/1", o_tmr_start, o_tmr_init, o_tmr_en, o_busy);
      end
      tick;
      checks++;
      if (o_tmr_start !== 1'b0 || o_tmr_en !== 1'b1) begin
         failures++;
         $display("FAIL exp_run start=%b en=%b exp=0/1", o_tmr_start, o_tmr_en);
      end
      repeat (3) tick;
      i_tmr_sec = 4'd0; i_tmr_timeout = 1'b1;
      tick;
      i_tmr_timeout = 1'b0;
      checks++;
      if (flags !== 5'b00010 || o_disp_bcd !== 8'h00) begin
         failures++;
         $display("FAIL exp_expire flags=%b bcd=%h exp=00010/00", flags, o_disp_bcd);
      end
      i_pause = 1'b1; i_done = 1'b1;
      tick;
      i_pause = 1'b0; i_done = 1'b0;
      checks++;
      if (flags !== 5'b00010) begin
         failures++;
         $display("FAIL exp_hold flags=%b exp=00010", flags);
      end
   endtask

   task automatic test_pause;
      i_tmr_sec = 4'd10; i_sec_cfg = 4'd0; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      checks++;
      if (o_tmr_init !== 4'd10 || o_disp_bcd !== 8'h10 || o_expired !== 1'b0) begin
         failures++;
         $display("FAIL pause_default init=%0d bcd=%h expd=%b exp=10/10/0", o_tmr_init, o_disp_bcd, o_expired);
      end
      tick;
      i_tmr_sec = 4'd7; i_pause = 1'b1;
      tick;
      i_pause = 1'b0;
      checks++;
      if (flags !== 5'b11000 || o_disp_bcd !== 8'h07) begin
         failures++;
         $display("FAIL pause_enter flags=%b bcd=%h exp=11000/07", flags, o_disp_bcd);
      end
      repeat (50) tick;
      checks++;
      if (flags !== 5'b11000 || o_disp_bcd !== 8'h07) begin
         failures++;
         $display("FAIL pause_hold flags=%b bcd=%h exp=11000/07", flags, o_disp_bcd);
      end
      i_pause = 1'b1;
      tick;
      i_pause = 1'b0;
      checks++;
      if (flags !== 5'b10001) begin
         failures++;
         $display("FAIL pause_resume flags=%b exp=10001", flags);
      end
   endtask

   task automatic test_done;
      i_tmr_sec = 4'd5; i_sec_cfg = 4'd5; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      tick;
      i_tmr_sec = 4'd4; i_done = 1'b1;
      tick;
      i_done = 1'b0;
      checks++;
      if (flags !== 5'b00100 || o_result_sec !== 4'd4 || o_disp_bcd !== 8'h04) begin
         failures++;
         $display("FAIL done_finish flags=%b res=%0d bcd=%h exp=00100/4/04", flags, o_result_sec, o_disp_bcd);
      end
      i_tmr_sec = 4'd2; i_tmr_timeout = 1'b1;
      tick;
      i_tmr_timeout = 1'b0;
      checks++;
      if (flags !== 5'b00100 || o_disp_bcd !== 8'h04 || o_disp_en !== 1'b1) begin
         failures++;
         $display("FAIL done_hold flags=%b bcd=%h den=%b exp=00100/04/1", flags, o_disp_bcd, o_disp_en);
      end
   endtask

   task automatic test_collisions;
      i_tmr_sec = 4'd6; i_sec_cfg = 4'd6; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      checks++;
      if (o_finished !== 1'b0) begin
         failures++;
         $display("FAIL coll_arm_clear fin=%b exp=0", o_finished);
      end
      tick;
      i_tmr_sec = 4'd2; i_done = 1'b1; i_tmr_timeout = 1'b1;
      tick;
      i_done = 1'b0; i_tmr_timeout = 1'b0;
      checks++;
      if (flags !== 5'b00010 || o_result_sec !== 4'd4 || o_disp_bcd !== 8'h00) begin
         failures++;
         $display("FAIL coll_done_timeout flags=%b res=%0d bcd=%h exp=00010/4/00", flags, o_result_sec, o_disp_bcd);
      end
      i_tmr_sec = 4'd6; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      tick;
      i_pause = 1'b1;
      tick;
      i_pause = 1'b0; i_tmr_timeout = 1'b1;
      tick;
      i_tmr_timeout = 1'b0;
      checks++;
      if (flags !== 5'b00010) begin
         failures++;
         $display("FAIL coll_pause_timeout flags=%b exp=00010", flags);
      end
   endtask

   task automatic test_blink;
      logic [7:0] pat;
      pat = 8'b11001100;
      i_tmr_sec = 4'd3; i_sec_cfg = 4'd3; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick;
         checks++;
         if (o_disp_en !== pat[7-i]) begin
            failures++;
            $display("FAIL blink_run[%0d] den=%b exp=%b", i, o_disp_en, pat[7-i]);
         end
      end
      i_pause = 1'b1;
      tick;
      i_pause = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (o_disp_en !== 1'b1 || o_paused !== 1'b1) begin
            failures++;
            $display("FAIL blink_pause[%0d] den=%b paused=%b exp=1/1", i, o_disp_en, o_paused);
         end
         tick;
      end
      i_pause = 1'b1;
      tick;
      i_pause = 1'b0;
      tick;
      tick;
      checks++;
      if (o_disp_en !== 1'b0) begin
         failures++;
         $display("FAIL blink_resume den=%b exp=0", o_disp_en);
      end
      i_tmr_sec = 4'd4;
      tick;
      tick;
      checks++;
      if (o_disp_en !== 1'b1 || o_disp_bcd !== 8'h04) begin
         failures++;
         $display("FAIL blink_outside den=%b bcd=%h exp=1/04", o_disp_en, o_disp_bcd);
      end
   endtask

   task automatic test_abort_reset;
      i_tmr_sec = 4'd9; i_sec_cfg = 4'd9; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      tick;
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      checks++;
      if (flags !== 5'b00000 || o_disp_en !== 1'b0 || o_disp_bcd !== 8'h00) begin
         failures++;
         $display("FAIL abort_idle flags=%b den=%b bcd=%h exp=00000/0/00", flags, o_disp_en, o_disp_bcd);
      end
      i_sec_cfg = 4'd8; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      tick;
      i_sec_cfg = 4'd7; i_arm = 1'b1; i_tmr_timeout = 1'b1;
      tick;
      i_arm = 1'b0; i_tmr_timeout = 1'b0;
      checks++;
      if (o_tmr_start !== 1'b1 || o_tmr_init !== 4'd7 || flags !== 5'b10000) begin
         failures++;
         $display("FAIL rearm_run start=%b init=%0d flags=%b exp=1/7/10000", o_tmr_start, o_tmr_init, flags);
      end
      i_sec_cfg = 4'd2; i_arm = 1'b1; i_abort = 1'b1;
      tick;
      i_arm = 1'b0; i_abort = 1'b0;
      checks++;
      if (flags !== 5'b00000 || o_tmr_start !== 1'b0 || o_tmr_init !== 4'd7) begin
         failures++;
         $display("FAIL abort_over_arm flags=%b start=%b init=%0d exp=00000/0/7", flags, o_tmr_start, o_tmr_init);
      end
      i_sec_cfg = 4'd5; i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      tick;
      rst_n = 1'b0;
      #1;
      checks++;
      if (flags !== 5'b00000 || o_tmr_init !== 4'd10 || o_disp_bcd !== 8'h00 || o_result_sec !== 4'd0) begin
         failures++;
         $display("FAIL reset_mid_run flags=%b init=%0d bcd=%h res=%0d exp=00000/10/00/0", flags, o_tmr_init, o_disp_bcd, o_result_sec);
      end
      tick;
      rst_n = 1'b1;
      tick;
      checks++;
      if (flags !== 5'b00000 || o_tmr_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_release flags=%b start=%b exp=00000/0", flags, o_tmr_start);
      end
   endtask

   initial begin
      test_reset;
      test_expiry;
      test_pause;
      test_done;
      test_collisions;
      test_blink;
      test_abort_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
